// File: rtl/multicycle_control.sv
// Multi-cycle control unit: sequences fetch/decode/execute/memory/writeback
// phases, handshakes with memory via MemAck with a timeout, and tracks
// retired instructions, run/halt control and error flags.
// Optional feature macro: ILLEGAL_TRAP_EN (trap illegal opcodes into HALTED
// instead of retiring them as NOPs).
module multicycle_control #(
   parameter int OPW         = 3,
   parameter int ALUOPW      = 3,
   parameter int CNTW        = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              Start,
   input  logic              Halt,
   input  logic [OPW-1:0]    Instr,
   input  logic              MemAck,
   input  logic              Zero,
   output logic              InstrReq,
   output logic              IRWrite,
   output logic              PCWrite,
   output logic              Branch,
   output logic              MemRead,
   output logic              MemWrite,
   output logic              MemtoReg,
   output logic              ALUSrc,
   output logic              RegWrite,
   output logic              Move,
   output logic [ALUOPW-1:0] ALUOp,
   output logic              Busy,
   output logic              Done,
   output logic [CNTW-1:0]   InstrCount,
   output logic              MemErr,
   output logic              IllegalOp
);

   localparam int WCW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MEM_TIMEOUT - 1);

   localparam logic [2:0] OP_BEQ   = 3'b011;
   localparam logic [2:0] OP_MOVE  = 3'b100;
   localparam logic [2:0] OP_LOAD  = 3'b101;
   localparam logic [2:0] OP_STORE = 3'b110;

   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED
   } state_t;

   state_t             state, next_state;
   logic [OPW-1:0]     opcode;
   logic [2:0]         op_low;
   logic [ALUOPW-1:0]  alu_val;
   logic               illegal;
   logic               halt_pending;
   logic [WCW-1:0]     wait_cnt;
   logic               complete;
   logic               timeout;
   logic               set_illegal;
   logic               illegal_flag;

   assign op_low  = opcode[2:0];
   assign alu_val = ALUOPW'(op_low);

   // Any opcode bit above bit 2 makes the instruction illegal
   generate
      if (OPW > 3) begin : g_wide_op
         assign illegal = |opcode[OPW-1:3];
      end else begin : g_narrow_op
         assign illegal = 1'b0;
      end
   endgenerate

   // Next-state and per-phase strobe decode from registered state and opcode
   always_comb begin
      next_state  = state;
      InstrReq    = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      Branch      = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      ALUSrc      = 1'b0;
      RegWrite    = 1'b0;
      Move        = 1'b0;
      ALUOp       = '0;
      Done        = 1'b0;
      complete    = 1'b0;
      timeout     = 1'b0;
      set_illegal = 1'b0;
      case (state)
         IDLE: begin
            if (Start) next_state = FETCH;
         end
         FETCH: begin
            InstrReq = 1'b1;
            if (MemAck) begin
               IRWrite    = 1'b1;
               next_state = DECODE;
            end else if (wait_cnt == WAIT_LIMIT) begin
               timeout    = 1'b1;
               next_state = HALTED;
            end
         end
         DECODE: begin
            if (illegal) begin
`ifdef ILLEGAL_TRAP_EN
               set_illegal = 1'b1;
               next_state  = HALTED;
`else
               next_state  = WB;
`endif
            end else begin
               next_state = EXEC;
            end
         end
         EXEC: begin
            ALUOp = alu_val;
            if (op_low == OP_BEQ) begin
               PCWrite  = 1'b1;
               Branch   = Zero;
               complete = 1'b1;
            end else if (op_low == OP_LOAD || op_low == OP_STORE) begin
               next_state = MEM;
            end else begin
               next_state = WB;
            end
         end
         MEM: begin
            if (op_low == OP_STORE) MemWrite = 1'b1;
            else                    MemRead  = 1'b1;
            if (MemAck) begin
               if (op_low == OP_STORE) begin
                  PCWrite  = 1'b1;
                  complete = 1'b1;
               end else begin
                  next_state = WB;
               end
            end else if (wait_cnt == WAIT_LIMIT) begin
               timeout    = 1'b1;
               next_state = HALTED;
            end
         end
         WB: begin
            PCWrite  = 1'b1;
            complete = 1'b1;
            if (!illegal) begin
               RegWrite = 1'b1;
               ALUOp    = alu_val;
               MemtoReg = (op_low == OP_LOAD);
               ALUSrc   = (op_low == OP_MOVE);
               Move     = (op_low == OP_MOVE);
            end
         end
         HALTED: begin
            if (Start && !MemErr && !illegal_flag) next_state = FETCH;
         end
         default: next_state = IDLE;
      endcase
      if (complete) begin
         Done       = 1'b1;
         next_state = (halt_pending || Halt) ? HALTED : FETCH;
      end
   end

   assign Busy = (state == FETCH) || (state == DECODE) || (state == EXEC) ||
                 (state == MEM)   || (state == WB);

   // State register
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= next_state;
   end

   // Opcode register loads on the fetch acknowledge
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)                          opcode <= '0;
      else if (state == FETCH && MemAck)     opcode <= Instr;
   end

   // Halt request latch, cleared whenever HALTED is entered
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)                                         halt_pending <= 1'b0;
      else if (next_state == HALTED && state != HALTED)     halt_pending <= 1'b0;
      else if (Busy && Halt)                                halt_pending <= 1'b1;
   end

   // Memory wait counter, restarted on every state change
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)                                   wait_cnt <= '0;
      else if (next_state != state)                   wait_cnt <= '0;
      else if ((state == FETCH || state == MEM) && !MemAck)
                                                      wait_cnt <= wait_cnt + 1'b1;
   end

   // Retired-instruction counter, wraps naturally
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)      InstrCount <= '0;
      else if (complete) InstrCount <= InstrCount + 1'b1;
   end

   // Sticky memory timeout flag
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)     MemErr <= 1'b0;
      else if (timeout) MemErr <= 1'b1;
   end

`ifdef ILLEGAL_TRAP_EN
   // Sticky illegal-opcode flag
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)         illegal_flag <= 1'b0;
      else if (set_illegal) illegal_flag <= 1'b1;
   end
`else
   assign illegal_flag = 1'b0 & set_illegal;
`endif

   assign IllegalOp = illegal_flag;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (OPW=4, CNTW=4,
// MEM_TIMEOUT=4).
module tb_multicycle_control;

   logic       Clk;
   logic       Reset_n;
   logic       Start, Halt, MemAck, Zero;
   logic [3:0] Instr;
   logic       InstrReq, IRWrite, PCWrite, Branch, MemRead, MemWrite;
   logic       MemtoReg, ALUSrc, RegWrite, Move, Busy, Done, MemErr, IllegalOp;
   logic [2:0] ALUOp;
   logic [3:0] InstrCount;

   int checkCount = 0;
   int failCount  = 0;

   multicycle_control #(
      .OPW(4), .ALUOPW(3), .CNTW(4), .MEM_TIMEOUT(4)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Halt(Halt),
      .Instr(Instr), .MemAck(MemAck), .Zero(Zero),
      .InstrReq(InstrReq), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite),
      .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
      .Move(Move), .ALUOp(ALUOp), .Busy(Busy), .Done(Done),
      .InstrCount(InstrCount), .MemErr(MemErr), .IllegalOp(IllegalOp)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Global time bound so the run can never hang
   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, then settle
   task automatic applyStimulus(input logic start, input logic halt,
                                input logic [3:0] instr, input logic ack,
                                input logic zero);
      @(negedge Clk);
      Start  = start;
      Halt   = halt;
      Instr  = instr;
      MemAck = ack;
      Zero   = zero;
      #1;
   endtask

   // Directed sequence
   initial begin
      Reset_n = 1'b0;
      Start = 0; Halt = 0; Instr = 0; MemAck = 0; Zero = 0;

      applyStimulus(0, 0, 4'h0, 0, 0);
      checkOutput("rst_busy", Busy, 0);
      checkOutput("rst_count", InstrCount, 0);
      checkOutput("rst_memerr", MemErr, 0);
      checkOutput("rst_illegal", IllegalOp, 0);
      checkOutput("rst_strobes", {InstrReq, PCWrite, RegWrite, Done, ALUOp}, 0);
      Reset_n = 1'b1;

      // add, acked on the first fetch cycle
      applyStimulus(1, 0, 4'h0, 0, 0);
      checkOutput("idle_busy", Busy, 0);
      applyStimulus(0, 0, 4'h0, 1, 0);
      checkOutput("add_fetch_req", InstrReq, 1);
      checkOutput("add_fetch_irw", IRWrite, 1);
      checkOutput("add_fetch_busy", Busy, 1);
      applyStimulus(0, 0, 4'h0, 0, 0);
      checkOutput("add_dec_irw", IRWrite, 0);
      checkOutput("add_dec_busy", Busy, 1);
      applyStimulus(0, 0, 4'h0, 0, 0);
      checkOutput("add_exec_pcw", PCWrite, 0);
      checkOutput("add_exec_done", Done, 0);
      applyStimulus(0, 0, 4'h0, 0, 0);
      checkOutput("add_wb_regw", RegWrite, 1);
      checkOutput("add_wb_pcw", PCWrite, 1);
      checkOutput("add_wb_done", Done, 1);
      checkOutput("add_wb_aluop", ALUOp, 0);

      // load, data ack on the fourth memory cycle
      applyStimulus(0, 0, 4'h5, 1, 0);
      checkOutput("add_count", InstrCount, 1);
      applyStimulus(0, 0, 4'h0, 0, 0);
      applyStimulus(0, 0, 4'h0, 0, 0);
      checkOutput("ld_exec_aluop", ALUOp, 5);
      checkOutput("ld_exec_memrd", MemRead, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 4'h0, 0, 0);
         checkOutput("ld_mem_wait_rd", MemRead, 1);
         checkOutput("ld_mem_wait_busy", Busy, 1);
      end
      applyStimulus(0, 0, 4'h0, 1, 0);
      checkOutput("ld_mem_ack_rd", MemRead, 1);
      checkOutput("ld_mem_ack_err", MemErr, 0);
      applyStimulus(0, 0, 4'h0, 0, 0);
      checkOutput("ld_wb_m2r", MemtoReg, 1);
      checkOutput("ld_wb_regw", RegWrite, 1);
      checkOutput("ld_wb_done", Done, 1);
      checkOutput("ld_wb_memrd", MemRead, 0);

      // store
      applyStimulus(0, 0, 4'h6, 1, 0);
      checkOutput("ld_count", InstrCount, 2);
      applyStimulus(0, 0, 4'h0, 0, 0);
      applyStimulus(0, 0, 4'h0, 0, 0);
      applyStimulus(0, 0, 4'h0, 0, 0);
      checkOutput("st_mem_wr", MemWrite, 1);
      checkOutput("st_mem_rd", MemRead, 0);
      checkOutput("st_mem_regw", RegWrite, 0);
      checkOutput("st_mem_pcw", PCWrite, 0);
      applyStimulus(0, 0, 4'h0, 1, 0);
      checkOutput("st_ack_wr", MemWrite, 1);
      checkOutput("st_ack_pcw", PCWrite, 1);
      checkOutput("st_ack_done", Done, 1);
      checkOutput("st_ack_regw", RegWrite, 0);

      // beq taken
      applyStimulus(0, 0, 4'h3, 1, 0);
      checkOutput("st_count", InstrCount, 3);
      applyStimulus(0, 0, 4'h0, 0, 0);
      applyStimulus(0, 0, 4'h0, 0, 1);
      checkOutput("beq1_branch", Branch, 1);
      checkOutput("beq1_pcw", PCWrite, 1);
      checkOutput("beq1_done", Done, 1);
      checkOutput("beq1_regw", RegWrite, 0);
      checkOutput("beq1_aluop", ALUOp, 3);

      // beq not taken
      applyStimulus(0, 0, 4'h3, 1, 0);
      checkOutput("beq1_count", InstrCount, 4);
      applyStimulus(0, 0, 4'h0, 0, 0);
      applyStimulus(0, 0, 4'h0, 0, 0);
      checkOutput("beq0_branch", Branch, 0);
      checkOutput("beq0_pcw", PCWrite, 1);
      checkOutput("beq0_done", Done, 1);

      // move
      applyStimulus(0, 0, 4'h4, 1, 0);
      checkOutput("beq0_count", InstrCount, 5);
      applyStimulus(0, 0, 4'h0, 0, 0);
      applyStimulus(0, 0, 4'h0, 0, 0);
      checkOutput("mv_exec_aluop", ALUOp, 4);
      applyStimulus(0, 0, 4'h0, 0, 0);
      checkOutput("mv_wb_alusrc", ALUSrc, 1);
      checkOutput("mv_wb_move", Move, 1);
      checkOutput("mv_wb_regw", RegWrite, 1);
      checkOutput("mv_wb_m2r", MemtoReg, 0);

      // nine more moves bring the count to 15
      for (int i = 0; i < 9; i++) begin
         applyStimulus(0, 0, 4'h4, 1, 0);
         applyStimulus(0, 0, 4'h0, 0, 0);
         applyStimulus(0, 0, 4'h0, 0, 0);
         applyStimulus(0, 0, 4'h0, 0, 0);
         checkOutput("mv_loop_done", Done, 1);
      end

      // final move with a one-cycle Halt pulse, count wraps to 0
      applyStimulus(0, 0, 4'h4, 1, 0);
      checkOutput("wrap_pre_count", InstrCount, 15);
      applyStimulus(0, 1, 4'h0, 0, 0);
      applyStimulus(0, 0, 4'h0, 0, 0);
      applyStimulus(0, 0, 4'h0, 0, 0);
      checkOutput("wrap_wb_done", Done, 1);
      applyStimulus(0, 0, 4'h0, 0, 0);
      checkOutput("halted_busy", Busy, 0);
      checkOutput("wrap_count", InstrCount, 0);
      checkOutput("halted_req", InstrReq, 0);
      applyStimulus(1, 0, 4'h0, 0, 0);
      checkOutput("halted_start_busy", Busy, 0);

      // resume, then fetch timeout after four unacknowledged cycles
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 4'h0, 0, 0);
         checkOutput("to_fetch_req", InstrReq, 1);
         checkOutput("to_fetch_err", MemErr, 0);
      end
      applyStimulus(0, 0, 4'h0, 0, 0);
      checkOutput("to_last_req", InstrReq, 1);
      checkOutput("to_last_err", MemErr, 0);
      checkOutput("to_last_done", Done, 0);
      applyStimulus(0, 0, 4'h0, 0, 0);
      checkOutput("to_memerr", MemErr, 1);
      checkOutput("to_busy", Busy, 0);
      checkOutput("to_done", Done, 0);
      applyStimulus(1, 0, 4'h0, 0, 0);
      checkOutput("to_start_busy", Busy, 0);
      applyStimulus(0, 0, 4'h0, 0, 0);
      checkOutput("to_stuck_busy", Busy, 0);
      checkOutput("to_stuck_req", InstrReq, 0);
      checkOutput("to_count", InstrCount, 0);

      // asynchronous reset clears the sticky error
      Reset_n = 1'b0;
      #1;
      checkOutput("rst2_memerr", MemErr, 0);
      Reset_n = 1'b1;

      // Halt in IDLE must not stop the next instruction's successor fetch
      applyStimulus(0, 1, 4'h0, 0, 0);
      checkOutput("idle_halt_busy", Busy, 0);
      applyStimulus(1, 0, 4'h0, 0, 0);
      applyStimulus(0, 0, 4'h0, 1, 0);
      applyStimulus(0, 0, 4'h0, 0, 0);
      applyStimulus(0, 0, 4'h0, 0, 0);
      applyStimulus(0, 0, 4'h0, 0, 0);
      checkOutput("idle_halt_wb_done", Done, 1);
      applyStimulus(0, 0, 4'h0, 1, 0);
      checkOutput("idle_halt_fetch_req", InstrReq, 1);
      checkOutput("idle_halt_count", InstrCount, 1);

      // reset in the middle of an add aborts it
      applyStimulus(0, 0, 4'h0, 0, 0);
      applyStimulus(0, 0, 4'h0, 0, 0);
      checkOutput("abort_exec_busy", Busy, 1);
      Reset_n = 1'b0;
      #1;
      checkOutput("abort_pcw", PCWrite, 0);
      checkOutput("abort_done", Done, 0);
      checkOutput("abort_busy", Busy, 0);
      checkOutput("abort_count", InstrCount, 0);
      Reset_n = 1'b1;

      // illegal opcode 1000
      applyStimulus(1, 0, 4'h0, 0, 0);
      applyStimulus(0, 0, 4'h8, 1, 0);
      checkOutput("ill_fetch_irw", IRWrite, 1);
      applyStimulus(0, 0, 4'h0, 0, 0);
      checkOutput("ill_dec_busy", Busy, 1);
`ifdef ILLEGAL_TRAP_EN
      applyStimulus(0, 0, 4'h0, 0, 0);
      checkOutput("ill_trap_flag", IllegalOp, 1);
      checkOutput("ill_trap_busy", Busy, 0);
      checkOutput("ill_trap_pcw", PCWrite, 0);
      checkOutput("ill_trap_done", Done, 0);
      applyStimulus(1, 0, 4'h0, 0, 0);
      applyStimulus(0, 0, 4'h0, 0, 0);
      checkOutput("ill_trap_stuck", Busy, 0);
      checkOutput("ill_trap_count", InstrCount, 0);
`else
      applyStimulus(0, 0, 4'h0, 0, 0);
      checkOutput("ill_nop_pcw", PCWrite, 1);
      checkOutput("ill_nop_regw", RegWrite, 0);
      checkOutput("ill_nop_done", Done, 1);
      checkOutput("ill_nop_flag", IllegalOp, 0);
      applyStimulus(0, 0, 4'h0, 0, 0);
      checkOutput("ill_nop_count", InstrCount, 1);
      checkOutput("ill_nop_next_req", InstrReq, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
